// File: rtl/ram_2r2w_pkg.sv
// rtl/ram_2r2w_pkg.sv - shared defaults and request encodings for the 2R2W RAM master
package ram_2r2w_pkg;

    localparam int DATA_SIZE_DEF      = 16;
    localparam int RAM_DEPTH_LOG2_DEF = 5;

    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_type_e;

endpackage

// File: rtl/ram_rsp_fifo.sv
// rtl/ram_rsp_fifo.sv - per-port read response FIFO with occupancy count
module ram_rsp_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data,
    output logic [CW-1:0]    count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];
    assign do_pop     = pop_ready & head_valid;
    // A push into a full FIFO is allowed when the head leaves in the same cycle.
    assign do_push    = push_valid & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_2r2w_master.sv
// rtl/ram_2r2w_master.sv - two-port request issue, collision stall and buffered read return for a 2R2W RAM
module ram_2r2w_master
    import ram_2r2w_pkg::*;
#(
    parameter int DATA_SIZE      = DATA_SIZE_DEF,
    parameter int RAM_DEPTH_LOG2 = RAM_DEPTH_LOG2_DEF,
    parameter int RD_LATENCY     = 1,
    parameter int RSP_DEPTH      = 2
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic                      req1_write,
    input  logic [RAM_DEPTH_LOG2-1:0] req1_addr,
    input  logic [DATA_SIZE-1:0]      req1_wdata,
    input  logic                      req2_valid,
    output logic                      req2_ready,
    input  logic                      req2_write,
    input  logic [RAM_DEPTH_LOG2-1:0] req2_addr,
    input  logic [DATA_SIZE-1:0]      req2_wdata,
    output logic                      rsp1_valid,
    input  logic                      rsp1_ready,
    output logic [DATA_SIZE-1:0]      rsp1_rdata,
    output logic                      rsp2_valid,
    input  logic                      rsp2_ready,
    output logic [DATA_SIZE-1:0]      rsp2_rdata,
    output logic                      ram_rden1,
    output logic                      ram_wren1,
    output logic [RAM_DEPTH_LOG2-1:0] ram_addr1,
    output logic [DATA_SIZE-1:0]      ram_wdata1,
    input  logic [DATA_SIZE-1:0]      ram_rdata1,
    output logic                      ram_rden2,
    output logic                      ram_wren2,
    output logic [RAM_DEPTH_LOG2-1:0] ram_addr2,
    output logic [DATA_SIZE-1:0]      ram_wdata2,
    input  logic [DATA_SIZE-1:0]      ram_rdata2
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = CW + 1;

    logic [1:0]                req_valid;
    logic [1:0]                req_write;
    logic [1:0]                req_ready;
    logic [1:0]                rsp_ready;
    logic [1:0]                rsp_valid;
    logic [1:0]                ram_rden;
    logic [1:0]                ram_wren;
    logic [RAM_DEPTH_LOG2-1:0] req_addr  [2];
    logic [RAM_DEPTH_LOG2-1:0] ram_addr  [2];
    logic [DATA_SIZE-1:0]      req_wdata [2];
    logic [DATA_SIZE-1:0]      ram_wdata [2];
    logic [DATA_SIZE-1:0]      ram_rdata [2];
    logic [DATA_SIZE-1:0]      rsp_rdata [2];
    logic                      collision;
    logic                      active_q;

    assign req_valid    = {req2_valid, req1_valid};
    assign req_write    = {req2_write, req1_write};
    assign rsp_ready    = {rsp2_ready, rsp1_ready};
    assign req_addr[0]  = req1_addr;
    assign req_addr[1]  = req2_addr;
    assign req_wdata[0] = req1_wdata;
    assign req_wdata[1] = req2_wdata;
    assign ram_rdata[0] = ram_rdata1;
    assign ram_rdata[1] = ram_rdata2;

    assign req1_ready = req_ready[0];
    assign req2_ready = req_ready[1];
    assign rsp1_valid = rsp_valid[0];
    assign rsp2_valid = rsp_valid[1];
    assign rsp1_rdata = rsp_rdata[0];
    assign rsp2_rdata = rsp_rdata[1];
    assign ram_rden1  = ram_rden[0];
    assign ram_rden2  = ram_rden[1];
    assign ram_wren1  = ram_wren[0];
    assign ram_wren2  = ram_wren[1];
    assign ram_addr1  = ram_addr[0];
    assign ram_addr2  = ram_addr[1];
    assign ram_wdata1 = ram_wdata[0];
    assign ram_wdata2 = ram_wdata[1];

    // Same-address double write: port 1 goes first, port 2 lands a cycle later and wins.
    assign collision = (&req_valid) & (&req_write) & (req_addr[0] == req_addr[1]);

    // Holds ready low while reset is applied without feeding reset into the datapath.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
        end else begin
            active_q <= 1'b1;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        logic                      is_write;
        logic                      stall;
        logic                      rd_accept;
        logic                      wr_accept;
        logic                      capture;
        logic                      rden_q;
        logic                      wren_q;
        logic [RAM_DEPTH_LOG2-1:0] addr_q;
        logic [DATA_SIZE-1:0]      wdata_q;
        logic [RD_LATENCY-1:0]     tag_q;
        logic [CW-1:0]             inflight_q;
        logic [CW-1:0]             fifo_count;
        logic [OW-1:0]             outstanding;

        assign is_write    = (req_type_e'(req_write[p]) == REQ_WRITE);
        assign stall       = (p == 1) ? collision : 1'b0;
        assign outstanding = OW'(inflight_q) + OW'(fifo_count);
        assign req_ready[p] = active_q & (is_write | (outstanding < OW'(RSP_DEPTH))) & ~stall;
        assign rd_accept   = req_valid[p] & req_ready[p] & ~is_write;
        assign wr_accept   = req_valid[p] & req_ready[p] & is_write;
        assign capture     = tag_q[RD_LATENCY-1];

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rden_q     <= 1'b0;
                wren_q     <= 1'b0;
                addr_q     <= '0;
                wdata_q    <= '0;
                tag_q      <= '0;
                inflight_q <= '0;
            end else begin
                rden_q  <= rd_accept;
                wren_q  <= wr_accept;
                addr_q  <= (rd_accept | wr_accept) ? req_addr[p] : '0;
                wdata_q <= wr_accept ? req_wdata[p] : '0;
                // Tag marks the cycle in which the RAM presents data for an issued read.
                tag_q   <= (tag_q << 1) | RD_LATENCY'(rden_q);
                case ({rd_accept, capture})
                    2'b10:   inflight_q <= inflight_q + 1'b1;
                    2'b01:   inflight_q <= inflight_q - 1'b1;
                    default: inflight_q <= inflight_q;
                endcase
            end
        end

        ram_rsp_fifo #(
            .WIDTH (DATA_SIZE),
            .DEPTH (RSP_DEPTH)
        ) u_rsp_fifo (
            .clock      (clock),
            .reset      (reset),
            .push_valid (capture),
            .push_data  (ram_rdata[p]),
            .pop_ready  (rsp_ready[p]),
            .head_valid (rsp_valid[p]),
            .head_data  (rsp_rdata[p]),
            .count      (fifo_count)
        );

        assign ram_rden[p]  = rden_q;
        assign ram_wren[p]  = wren_q;
        assign ram_addr[p]  = addr_q;
        assign ram_wdata[p] = wdata_q;
    end

endmodule

// File: tb/tb_ram_2r2w_master.sv
// tb/tb_ram_2r2w_master.sv - self-checking bench for ram_2r2w_master with a read-first RAM model
module tb_ram_2r2w_master;
    import ram_2r2w_pkg::*;

    localparam int DW    = DATA_SIZE_DEF;
    localparam int AW    = RAM_DEPTH_LOG2_DEF;
    localparam int DEPTH = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    rv    = '0;
    logic [1:0]    rw    = '0;
    logic [1:0]    rrdy  = 2'b11;
    logic [AW-1:0] ra  [2];
    logic [DW-1:0] rwd [2];

    logic          req1_ready, req2_ready, rsp1_valid, rsp2_valid;
    logic [DW-1:0] rsp1_rdata, rsp2_rdata;
    logic          ram_rden1, ram_wren1, ram_rden2, ram_wren2;
    logic [AW-1:0] ram_addr1, ram_addr2;
    logic [DW-1:0] ram_wdata1, ram_wdata2, ram_rdata1, ram_rdata2;

    logic [1:0]    rsp_v;
    logic [DW-1:0] rsp_d [2];
    assign rsp_v    = {rsp2_valid, rsp1_valid};
    assign rsp_d[0] = rsp1_rdata;
    assign rsp_d[1] = rsp2_rdata;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
        bit            strict;
    } exp_t;

    typedef struct {
        bit            v1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        bit            v2, w2;
        logic [AW-1:0] a2;
        logic [DW-1:0] d2;
        bit            r1, r2;
    } vec_t;

    exp_t          sbq [2][$];
    logic [DW-1:0] ref_mem [1 << AW];
    logic [DW-1:0] ram_mem [1 << AW];
    int            out_cnt [2];
    int            cyc    = 0;
    int            errors = 0;
    int            checks = 0;
    bit            strict = 1'b1;
    logic [1:0]    rdy_s;

    ram_2r2w_master dut (
        .clock      (clock),
        .reset      (reset),
        .req1_valid (rv[0]),
        .req1_ready (req1_ready),
        .req1_write (rw[0]),
        .req1_addr  (ra[0]),
        .req1_wdata (rwd[0]),
        .req2_valid (rv[1]),
        .req2_ready (req2_ready),
        .req2_write (rw[1]),
        .req2_addr  (ra[1]),
        .req2_wdata (rwd[1]),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rrdy[0]),
        .rsp1_rdata (rsp1_rdata),
        .rsp2_valid (rsp2_valid),
        .rsp2_ready (rrdy[1]),
        .rsp2_rdata (rsp2_rdata),
        .ram_rden1  (ram_rden1),
        .ram_wren1  (ram_wren1),
        .ram_addr1  (ram_addr1),
        .ram_wdata1 (ram_wdata1),
        .ram_rdata1 (ram_rdata1),
        .ram_rden2  (ram_rden2),
        .ram_wren2  (ram_wren2),
        .ram_addr2  (ram_addr2),
        .ram_wdata2 (ram_wdata2),
        .ram_rdata2 (ram_rdata2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Read-first RAM with one cycle of read latency.
    always @(posedge clock) begin
        if (ram_rden1) ram_rdata1 <= ram_mem[ram_addr1];
        if (ram_rden2) ram_rdata2 <= ram_mem[ram_addr2];
        if (ram_wren1) ram_mem[ram_addr1] <= ram_wdata1;
        if (ram_wren2) ram_mem[ram_addr2] <= ram_wdata2;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        #2;
        if (!reset) begin
            chk("strobe_excl1", ram_rden1 & ram_wren1, 0);
            chk("strobe_excl2", ram_rden2 & ram_wren2, 0);
            for (int p = 0; p < 2; p++) begin
                if (rsp_v[p] && rrdy[p]) begin
                    if (sbq[p].size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp%0d: got %0h expected none", p + 1, rsp_d[p]);
                    end else begin
                        e = sbq[p].pop_front();
                        chk($sformatf("rsp%0d_data", p + 1), rsp_d[p], e.data);
                        if (e.strict) chk($sformatf("rsp%0d_latency", p + 1), cyc - e.cyc, 3);
                        out_cnt[p]--;
                    end
                end
            end
        end
    end

    task automatic set_req(input int p, input bit v, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        rv[p]  = v;
        rw[p]  = w;
        ra[p]  = a;
        rwd[p] = d;
    endtask

    // One request cycle: check ready against the credit/collision model, book accepts, advance.
    task automatic step();
        logic [1:0] er;
        exp_t       n;
        #1;
        for (int p = 0; p < 2; p++) er[p] = !reset && (rw[p] || out_cnt[p] < DEPTH);
        if (rv[0] && rv[1] && rw[0] && rw[1] && ra[0] == ra[1]) er[1] = 1'b0;
        rdy_s = {req2_ready, req1_ready};
        for (int p = 0; p < 2; p++) begin
            if (rv[p]) chk($sformatf("req%0d_ready_model", p + 1), rdy_s[p], er[p]);
        end
        for (int p = 0; p < 2; p++) begin
            if (rv[p] && rdy_s[p] && !rw[p]) begin
                n.data   = ref_mem[ra[p]];
                n.cyc    = cyc;
                n.strict = strict;
                sbq[p].push_back(n);
                out_cnt[p]++;
            end
        end
        for (int p = 0; p < 2; p++) begin
            if (rv[p] && rdy_s[p] && rw[p]) ref_mem[ra[p]] = rwd[p];
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n  = 0;
        rv = '0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 40) begin
            step();
            n++;
        end
        chk("drain_done", sbq[0].size() + sbq[1].size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        int   idx;
        int   acc1, acc2;

        for (int p = 0; p < 2; p++) begin
            ra[p]      = '0;
            rwd[p]     = '0;
            out_cnt[p] = 0;
        end

        tbl[0] = '{1'b1, 1'b1, 5'd0,  16'habcd, 1'b1, 1'b1, 5'd1,  16'hef01, 1'b1, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 5'd1,  16'h0000, 1'b1, 1'b0, 5'd0,  16'h0000, 1'b1, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 5'd7,  16'h1234, 1'b0, 1'b0, 5'd0,  16'h0000, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 5'd7,  16'h00ff, 1'b1, 1'b0, 5'd7,  16'h0000, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 5'd7,  16'h0000, 1'b1, 1'b0, 5'd7,  16'h0000, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 5'd31, 16'hbeef, 1'b1, 1'b1, 5'd0,  16'h5a5a, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 5'd31, 16'h0000, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 5'd0,  16'h0000, 1'b1, 1'b0, 5'd7,  16'h0000, 1'b0, 1'b1};

        repeat (2) @(negedge clock);
        #1;
        chk("rst_ram1", {ram_rden1, ram_wren1, ram_addr1, ram_wdata1}, 0);
        chk("rst_ram2", {ram_rden2, ram_wren2, ram_addr2, ram_wdata2}, 0);
        chk("rst_ready", {req1_ready, req2_ready}, 0);
        chk("rst_rsp_valid", {rsp1_valid, rsp2_valid}, 0);
        chk("rst_rsp1_rdata", rsp1_rdata, 0);
        chk("rst_rsp2_rdata", rsp2_rdata, 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        for (int i = 0; i < 16; i++) begin
            set_req(0, 1'b1, 1'b1, AW'(i), '0);
            set_req(1, 1'b1, 1'b1, AW'(16 + i), '0);
            step();
        end

        for (int i = 0; i < 8; i++) begin
            set_req(0, tbl[i].v1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
            set_req(1, tbl[i].v2, tbl[i].w2, tbl[i].a2, tbl[i].d2);
            step();
            if (tbl[i].v1) chk($sformatf("tbl%0d_ready1", i), rdy_s[0], tbl[i].r1);
            if (tbl[i].v2) chk($sformatf("tbl%0d_ready2", i), rdy_s[1], tbl[i].r2);
        end
        drain();

        set_req(0, 1'b1, 1'b1, 5'd5, 16'h1111);
        set_req(1, 1'b1, 1'b1, 5'd5, 16'h2222);
        step();
        chk("coll_ready1", rdy_s[0], 1);
        chk("coll_ready2_stall", rdy_s[1], 0);
        chk("coll_wren_first", {ram_wren1, ram_wren2}, 2'b10);
        set_req(0, 1'b0, 1'b0, 5'd0, '0);
        step();
        chk("coll_ready2_next", rdy_s[1], 1);
        chk("coll_wren_second", {ram_wren1, ram_wren2}, 2'b01);
        chk("coll_wdata2", ram_wdata2, 16'h2222);
        rv = '0;
        step();
        set_req(0, 1'b1, 1'b0, 5'd5, '0);
        step();
        drain();

        strict  = 1'b0;
        rrdy[0] = 1'b0;
        idx     = 0;
        for (int c = 0; c < 6; c++) begin
            set_req(0, 1'b1, 1'b0, AW'(idx), '0);
            step();
            if (rdy_s[0]) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_ready_low", rdy_s[0], 0);
        chk("bp_rsp1_valid", rsp1_valid, 1);
        rrdy[0] = 1'b1;
        for (int c = 0; c < 30 && idx < 4; c++) begin
            set_req(0, 1'b1, 1'b0, AW'(idx), '0);
            step();
            if (rdy_s[0]) idx++;
        end
        chk("bp_all_accepted", idx, 4);
        drain();
        strict = 1'b1;

        acc1 = 0;
        acc2 = 0;
        for (int i = 0; i < 32; i++) begin
            set_req(0, 1'b1, 1'b1, AW'(i % 16), DW'($urandom));
            set_req(1, 1'b1, 1'b1, AW'(16 + i % 16), DW'($urandom));
            step();
            if (rdy_s[0]) acc1++;
            if (rdy_s[1]) acc2++;
        end
        chk("tp_wr_accepts1", acc1, 32);
        chk("tp_wr_accepts2", acc2, 32);
        acc1 = 0;
        acc2 = 0;
        for (int c = 0; c < 200 && (acc1 < 32 || acc2 < 32); c++) begin
            set_req(0, acc1 < 32, 1'b0, AW'(16 + acc1 % 16), '0);
            set_req(1, acc2 < 32, 1'b0, AW'(acc2 % 16), '0);
            step();
            if (rv[0] && rdy_s[0]) acc1++;
            if (rv[1] && rdy_s[1]) acc2++;
        end
        chk("tp_rd_accepts1", acc1, 32);
        chk("tp_rd_accepts2", acc2, 32);
        drain();

        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        set_req(1, 1'b1, 1'b0, 5'd20, '0);
        step();
        rv = '0;
        chk("mid_rden_inflight", {ram_rden1, ram_rden2}, 2'b11);
        reset = 1'b1;
        #1;
        chk("mid_rst_strobes", {ram_rden1, ram_rden2, ram_wren1, ram_wren2}, 0);
        chk("mid_rst_addr", {ram_addr1, ram_addr2}, 0);
        chk("mid_rst_ready", {req1_ready, req2_ready}, 0);
        chk("mid_rst_rsp_valid", {rsp1_valid, rsp2_valid}, 0);
        for (int p = 0; p < 2; p++) begin
            sbq[p].delete();
            out_cnt[p] = 0;
        end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            #1;
            chk("post_rst_no_rsp", {rsp1_valid, rsp2_valid}, 0);
        end
        @(negedge clock);
        set_req(0, 1'b1, 1'b0, 5'd3, '0);
        step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
